ddfs_core: RTL

- Direct digital frequency synthesis engine. It produces the 16-bit signed PCM sample that feeds the audio codec DAC data path, where it is duplicated to left and right.
- One sample is generated per codec sample tick: phase accumulator, then phase offset, then sine LUT, then envelope multiply with saturation.
- Control words arrive from the CPU-side register wrapper. They are double-buffered so that updates apply glitch-free, only on a sample boundary.

---
 rtl/ddfs_pkg.sv | 28 ++
 rtl/ddfs_sin_rom.sv | 53 +++++
 rtl/ddfs_core.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ddfs_pkg.sv
// Shared widths, constants and types for the DDFS engine.
// Control words travel as one packed bundle through the double buffer.
package ddfs_pkg;
  localparam int PW = 30;
  localparam int LUT_AW = 10;
  localparam int DW = 16;

  typedef logic [PW-1:0] phase_t;
  typedef logic signed [DW-1:0] pcm_t;

  localparam pcm_t ENV_UNITY = 16'h4000;
  localparam pcm_t PCM_MAX = 16'h7FFF;
  localparam pcm_t PCM_MIN = 16'h8000;

  typedef struct packed {
    phase_t fccw;
    phase_t focw;
    phase_t pha;
    pcm_t   env;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{
    fccw: '0,
    focw: '0,
    pha:  '0,
    env:  ENV_UNITY
  };
endpackage

// File: rtl/ddfs_sin_rom.sv
// Full-wave sine ROM, one-cycle synchronous read.
// Entries are elaboration-time constants from a fixed-point Taylor series.
module ddfs_sin_rom
  import ddfs_pkg::*;
(
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output pcm_t              data_q
);
  localparam int DEPTH = 2**LUT_AW;
  localparam longint TWO_PI_Q30 = 64'sd6746518852;

  // Quarter-wave fold, then sin(x) in Q30 and round to 32767 scale
  function automatic pcm_t sin_val(input int idx);
    logic [1:0] quad;
    longint j;
    longint x;
    longint x2;
    longint term;
    longint s;
    longint v;
    quad = 2'(idx >> (LUT_AW-2));
    j = longint'(idx % (DEPTH/4));
    if (quad[0]) j = longint'(DEPTH/4) - j;
    x = (j * TWO_PI_Q30 + longint'(DEPTH/2)) >>> LUT_AW;
    x2 = (x * x) >>> 30;
    term = x;
    s = x;
    for (int n = 1; n <= 7; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2*n) * (2*n+1)));
      s = s + term;
    end
    v = (s * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
    if (quad[1]) v = -v;
    return pcm_t'(v);
  endfunction

  pcm_t tbl [DEPTH];
  pcm_t data_d;

  for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
    localparam pcm_t VAL = sin_val(g);
    assign tbl[g] = VAL;
  end

  always_comb begin
    data_d = tbl[addr];
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end
endmodule

// File: rtl/ddfs_core.sv
// DDFS engine: accumulate, phase offset, sine lookup, envelope scale.
// Control words are shadowed and promoted only on accepted sample ticks.
module ddfs_core
  import ddfs_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   wr_ctrl,
  input  phase_t fccw,
  input  phase_t focw,
  input  phase_t pha,
  input  pcm_t   env,
  input  logic   sample_tick,
  output pcm_t   pcm_out,
  output logic   pcm_valid,
  output phase_t phase_q
);
  ctrl_t act_q, act_d;
  ctrl_t pend_q, pend_d;
  logic flag_q, flag_d;
  phase_t acc_q, acc_d;
  logic v0_q, v0_d;
  phase_t pha0_q, pha0_d;
  pcm_t env0_q, env0_d;
  logic [LUT_AW-1:0] addr1_q, addr1_d;
  logic v1_q, v1_d;
  pcm_t env1_q, env1_d;
  logic v2_q, v2_d;
  pcm_t env2_q, env2_d;
  pcm_t sin_q;
  pcm_t pcm_q, pcm_d;
  logic valid_q, valid_d;

  logic tick;
  phase_t sum;
  logic signed [2*DW-1:0] prod;

  ddfs_sin_rom u_rom (
    .clk    (clk),
    .addr   (addr1_q),
    .data_q (sin_q)
  );

  always_comb begin
    tick = sample_tick & en;
    act_d = act_q;
    pend_d = pend_q;
    flag_d = flag_q;
    if (wr_ctrl) begin
      pend_d = '{fccw: fccw, focw: focw, pha: pha, env: env};
      flag_d = 1'b1;
    end
    // A write landing with the promoting tick stays pending
    if (tick && flag_q) begin
      act_d = pend_q;
      flag_d = wr_ctrl;
    end
  end

  always_comb begin
    acc_d = acc_q;
    v0_d = tick;
    pha0_d = pha0_q;
    env0_d = env0_q;
    if (tick) begin
      acc_d = acc_q + act_q.fccw + act_q.focw;
      pha0_d = act_q.pha;
      env0_d = act_q.env;
    end
    sum = acc_q + pha0_q;
    v1_d = v0_q;
    addr1_d = v0_q ? LUT_AW'(sum >> (PW-LUT_AW)) : addr1_q;
    env1_d = v0_q ? env0_q : env1_q;
    v2_d = v1_q;
    env2_d = v1_q ? env1_q : env2_q;
    prod = sin_q * env2_q;
    valid_d = v2_q;
    pcm_d = pcm_q;
    if (v2_q) begin
      if (prod > 32'sh1FFF_FFFF) pcm_d = PCM_MAX;
      else if (prod < -32'sh2000_0000) pcm_d = PCM_MIN;
      else pcm_d = DW'(prod >>> 14);
    end
    if (!en) begin
      acc_d = '0;
      pcm_d = '0;
      v0_d = 1'b0;
      v1_d = 1'b0;
      v2_d = 1'b0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q <= CTRL_RST;
      pend_q <= CTRL_RST;
      flag_q <= 1'b0;
      acc_q <= '0;
      v0_q <= 1'b0;
      pha0_q <= '0;
      env0_q <= ENV_UNITY;
      addr1_q <= '0;
      v1_q <= 1'b0;
      env1_q <= ENV_UNITY;
      v2_q <= 1'b0;
      env2_q <= ENV_UNITY;
      pcm_q <= '0;
      valid_q <= 1'b0;
    end else begin
      act_q <= act_d;
      pend_q <= pend_d;
      flag_q <= flag_d;
      acc_q <= acc_d;
      v0_q <= v0_d;
      pha0_q <= pha0_d;
      env0_q <= env0_d;
      addr1_q <= addr1_d;
      v1_q <= v1_d;
      env1_q <= env1_d;
      v2_q <= v2_d;
      env2_q <= env2_d;
      pcm_q <= pcm_d;
      valid_q <= valid_d;
    end
  end

  assign pcm_out = pcm_q;
  assign pcm_valid = valid_q;
  assign phase_q = acc_q;
endmodule
